qed_consistency_monitor: RTL and testbench
==========================================

# qed_consistency_monitor

Parametrised, synthesisable SQED consistency monitor for the core's formal/bring-up harness. It counts original and duplicate register-file commits across N commit ports and compares every original register with its duplicate whenever the counts match. It latches the first mismatch with the failing register index and resolves each run to PASS or FAIL through a small state machine with a cycle timeout. It sits beside the architectural register file and observes the write ports and the flattened register contents.

## Interface
- `NUM_REGS`, 32: architectural registers. Must be even and ≥4. Originals are 1..H-1 and duplicates are H..NUM_REGS-1, with H = NUM_REGS/2.
- `XLEN`, 32: register width.
- `NUM_PORTS`, 2: commit (write) ports, 1..4.
- `CNT_W`, 16: width of the commit counters.
- `TIMEOUT`, 50: length of a run in RUN cycles.
- `REG_SEL`, $clog2(NUM_REGS): width of the register index.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  start request; sampled in IDLE only.
- `commit_we`  in  NUM_PORTS  per-port write enable.
- `commit_dst`  in  NUM_PORTS*REG_SEL  per-port destination; port p occupies bits [p*REG_SEL +: REG_SEL].
- `regs_flat`  in  NUM_REGS*XLEN  register contents; reg i occupies bits [i*XLEN +: XLEN].
- `qed_ready`  out  1  counts are equal and checking is enabled (combinational from registered state).
- `mismatch`  out  1  one-cycle pulse for the first detected mismatch.
- `mismatch_sticky`  out  1  set on the first mismatch; held until rst.
- `mismatch_idx`  out  REG_SEL  lowest failing original index, captured with the first mismatch.
- `num_orig`, `num_dup`  out  CNT_W each  commit counters.
- `cnt_sat`  out  1  either counter has saturated.
- `state`  out  2  IDLE=0, RUN=1, PASS=2, FAIL=3.

## Operation
- **Commit classification, per port.** A port with we=1 and dst=0 is ignored. A port with we=1 and 1≤dst<H is an original commit. A port with we=1 and dst≥H is a duplicate commit; this includes dst=H.
- **Per-cycle sums.** orig_commits and dup_commits are the per-cycle sums of those classifications, each with width $clog2(NUM_PORTS+1).
- **Counters.** Both counters update only in RUN: each adds its per-cycle sum and saturates at 2^CNT_W-1. They hold their value in IDLE, PASS and FAIL.
- **cnt_sat.** Sets when either counter reaches its maximum. It is sticky until rst.
- **qed_ready.** Equals (state==RUN) && (num_orig==num_dup) && !cnt_sat.
- **Compare.** While qed_ready=1, the block compares reg i with reg i+H for every i in 1..H-1. Any inequality is a hit; hit_idx is the smallest failing i.
- **Transitions.**
  - IDLE→RUN when enable=1.
  - RUN→FAIL on a hit. The same edge sets mismatch_sticky, captures mismatch_idx=hit_idx, and pulses mismatch for one cycle.
  - RUN→PASS when timer ≥ TIMEOUT-1 and there is no hit.
  - PASS and FAIL are terminal; only rst leaves them.
- **Simultaneous events.** A hit on the timeout cycle goes to FAIL. Commits in that same cycle still update the counters.
- **Timer.** Resets to 0 and increments every RUN cycle. Width is $clog2(TIMEOUT+1).
- **Reset mid-run.** rst at any point returns every register to its reset value on the next edge. Inputs in that cycle are ignored.

## Timing
- Reset values: state=IDLE, num_orig=num_dup=0, timer=0, mismatch=0, mismatch_sticky=0, mismatch_idx=0, cnt_sat=0. qed_ready is therefore 0.
- Counter latency: a commit at edge k shows in num_orig/num_dup after edge k.
- Compare latency: the compare uses the current regs_flat and the registered counters. A hit in cycle k gives mismatch=1, state=FAIL and a valid mismatch_idx in cycle k+1. mismatch returns to 0 in cycle k+2.
- Run length: with enable high in cycle 0, RUN spans cycles 1..TIMEOUT, and PASS is visible in cycle TIMEOUT+1 if no hit occurred.
- Initial check: qed_ready=1 in the first RUN cycle, because both counts are 0. The register file must therefore start consistent.

## Test plan
- **Balanced duplicate stream.** Defaults. In RUN, write r3=5 plus orig commit, then r19=5 plus dup commit, repeated. → counts alternate 1/0 then 1/1. No mismatch. PASS in cycle 51.
- **Injected corruption.** Defaults. r5=7, r21=9, counts equal in cycle 4 (r7/r23 also differ). → mismatch pulse in cycle 5, state=FAIL, mismatch_idx=5, sticky stays 1 for the rest of the run.
- **Multi-port commits.** Same cycle: port0 dst=2, port1 dst=18. → num_orig=num_dup=1 one cycle later. port0 dst=0 with port1 dst=16 → num_orig+0, num_dup+1. Both dst<H → num_orig+2.
- **Saturation.** CNT_W=4, 20 orig-only commits. → num_orig holds at 15, cnt_sat=1, qed_ready=0 even with unequal registers. Run ends in PASS.
- **Hit on timeout cycle.** Mismatch presented in cycle TIMEOUT with counts equal. → FAIL, not PASS.
- **Reset mid-run.** rst in cycle 10 of RUN with num_orig=3. → cycle 11: state=IDLE, counters 0, flags 0. A new enable restarts the run.

Source files
------------

// File: rtl/qed_consistency_monitor.sv
// SQED consistency monitor: balances original/duplicate commit counts and compares
// each original register with its duplicate whenever the counts agree.
module qed_consistency_monitor #(
    parameter int NUM_REGS  = 32,
    parameter int XLEN      = 32,
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 50,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_PORTS-1:0]          commit_we,
    input  logic [NUM_PORTS*REG_SEL-1:0]  commit_dst,
    input  logic [NUM_REGS*XLEN-1:0]      regs_flat,
    output logic                          qed_ready,
    output logic                          mismatch,
    output logic                          mismatch_sticky,
    output logic [REG_SEL-1:0]            mismatch_idx,
    output logic [CNT_W-1:0]              num_orig,
    output logic [CNT_W-1:0]              num_dup,
    output logic                          cnt_sat,
    output logic [1:0]                    state
);
    localparam int H     = NUM_REGS / 2;
    localparam int SUM_W = $clog2(NUM_PORTS + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [REG_SEL-1:0] H_IDX    = REG_SEL'(H);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   num_orig_q, num_orig_d, num_dup_q, num_dup_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               mismatch_q, mismatch_d, sticky_q, sticky_d, sat_q, sat_d;
    logic [REG_SEL-1:0] idx_q, idx_d;

    logic [SUM_W-1:0]   orig_sum, dup_sum;
    logic [REG_SEL-1:0] dst_p;
    logic               hit;
    logic [REG_SEL-1:0] hit_idx;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                  input logic [SUM_W-1:0] s);
        logic [CNT_W:0] t;
        t = {1'b0, c} + (CNT_W+1)'(s);
        return t[CNT_W] ? CNT_MAX : t[CNT_W-1:0];
    endfunction

    // Register 0 is hard-wired, so writes to it are not commits at all.
    always_comb begin
        orig_sum = '0;
        dup_sum  = '0;
        dst_p    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dst_p = commit_dst[p*REG_SEL +: REG_SEL];
            if (commit_we[p] && dst_p != '0) begin
                if (dst_p < H_IDX) orig_sum = orig_sum + SUM_W'(1);
                else               dup_sum  = dup_sum + SUM_W'(1);
            end
        end
    end

    assign qed_ready = (state_q == S_RUN) && (num_orig_q == num_dup_q) && !sat_q;

    // Scan downward so the lowest failing index is the one left in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = H - 1; i >= 1; i--) begin
            if (qed_ready &&
                regs_flat[i*XLEN +: XLEN] != regs_flat[(i+H)*XLEN +: XLEN]) begin
                hit     = 1'b1;
                hit_idx = REG_SEL'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        num_orig_d = num_orig_q;
        num_dup_d  = num_dup_q;
        timer_d    = timer_q;
        mismatch_d = 1'b0;
        sticky_d   = sticky_q;
        idx_d      = idx_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_RUN;
            S_RUN: begin
                num_orig_d = sat_add(num_orig_q, orig_sum);
                num_dup_d  = sat_add(num_dup_q, dup_sum);
                timer_d    = timer_q + TMR_W'(1);
                if (hit) begin
                    state_d    = S_FAIL;
                    mismatch_d = 1'b1;
                    sticky_d   = 1'b1;
                    idx_d      = hit_idx;
                end else if (timer_q >= TMR_LAST) begin
                    state_d = S_PASS;
                end
            end
            default: ;
        endcase
        sat_d = sat_q || (num_orig_d == CNT_MAX) || (num_dup_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_orig_q <= '0;
            num_dup_q  <= '0;
            timer_q    <= '0;
            mismatch_q <= 1'b0;
            sticky_q   <= 1'b0;
            idx_q      <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_orig_q <= num_orig_d;
            num_dup_q  <= num_dup_d;
            timer_q    <= timer_d;
            mismatch_q <= mismatch_d;
            sticky_q   <= sticky_d;
            idx_q      <= idx_d;
            sat_q      <= sat_d;
        end
    end

    assign state           = state_q;
    assign num_orig        = num_orig_q;
    assign num_dup         = num_dup_q;
    assign cnt_sat         = sat_q;
    assign mismatch        = mismatch_q;
    assign mismatch_sticky = sticky_q;
    assign mismatch_idx    = idx_q;
endmodule

// File: tb/tb_qed_consistency_monitor.sv
// Scoreboard bench: a run-level reference model predicts both monitors (wide and
// 4-bit counters) each cycle; a separate monitor process pops and compares.
module tb_qed_consistency_monitor;
    localparam int NR = 32, XL = 32, NP = 2, TO = 50, RS = 5, H = NR / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable;
    bit   we_v [NP];
    int   dst_v[NP];
    logic [XL-1:0] rf[NR];
    logic [NP-1:0]      commit_we;
    logic [NP*RS-1:0]   commit_dst;
    logic [NR*XL-1:0]   regs_flat;

    always_comb begin
        commit_we  = '0;
        commit_dst = '0;
        for (int p = 0; p < NP; p++) begin
            commit_we[p]           = we_v[p];
            commit_dst[p*RS +: RS] = RS'(dst_v[p]);
        end
        regs_flat = '0;
        for (int r = 0; r < NR; r++) regs_flat[r*XL +: XL] = rf[r];
    end

    logic rdy0, mm0, sk0, sat0, rdy1, mm1, sk1, sat1;
    logic [RS-1:0] idx0, idx1;
    logic [15:0] no0, nd0;
    logic [3:0]  no1, nd1;
    logic [1:0]  st0, st1;

    qed_consistency_monitor #(.NUM_REGS(NR), .XLEN(XL), .NUM_PORTS(NP), .CNT_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .commit_we(commit_we), .commit_dst(commit_dst),
        .regs_flat(regs_flat), .qed_ready(rdy0), .mismatch(mm0), .mismatch_sticky(sk0),
        .mismatch_idx(idx0), .num_orig(no0), .num_dup(nd0), .cnt_sat(sat0), .state(st0));

    qed_consistency_monitor #(.NUM_REGS(NR), .XLEN(XL), .NUM_PORTS(NP), .CNT_W(4), .TIMEOUT(TO)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .commit_we(commit_we), .commit_dst(commit_dst),
        .regs_flat(regs_flat), .qed_ready(rdy1), .mismatch(mm1), .mismatch_sticky(sk1),
        .mismatch_idx(idx1), .num_orig(no1), .num_dup(nd1), .cnt_sat(sat1), .state(st1));

    // Model state: st 0=IDLE 1=RUN 2=PASS 3=FAIL
    typedef struct { int st; int no; int nd; int tmr; int idx; bit sat; bit mm; bit sticky; } mdl_t;
    mdl_t m0 = '{default: 0}, m1 = '{default: 0};
    mdl_t q0[$], q1[$];
    int nchk = 0, nerr = 0, run_seen = 0;

    function automatic mdl_t step(input mdl_t m, input int cmax);
        mdl_t n = m;
        bit ready, found;
        int oc, dc, hidx;
        n.mm = 1'b0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        ready = (m.st == 1) && (m.no == m.nd) && !m.sat;
        found = 1'b0; hidx = 0;
        if (ready)
            for (int i = 1; i < H; i++)
                if (!found && rf[i] != rf[i+H]) begin found = 1'b1; hidx = i; end
        if (m.st == 0) begin
            if (enable) n.st = 1;
        end else if (m.st == 1) begin
            oc = 0; dc = 0;
            for (int p = 0; p < NP; p++)
                if (we_v[p] && dst_v[p] != 0) begin
                    if (dst_v[p] < H) oc++; else dc++;
                end
            n.no  = (m.no + oc > cmax) ? cmax : m.no + oc;
            n.nd  = (m.nd + dc > cmax) ? cmax : m.nd + dc;
            n.tmr = m.tmr + 1;
            if (found) begin n.st = 3; n.mm = 1'b1; n.sticky = 1'b1; n.idx = hidx; end
            else if (m.tmr >= TO - 1) n.st = 2;
        end
        if (n.no == cmax || n.nd == cmax) n.sat = 1'b1;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string d, input mdl_t e, input logic [1:0] st, input logic [31:0] no,
                       input logic [31:0] nd, input logic sat, input logic rdy, input logic mm,
                       input logic sk, input logic [RS-1:0] idx);
        chk({d, ".state"}, st, e.st);
        chk({d, ".num_orig"}, no, e.no);
        chk({d, ".num_dup"}, nd, e.nd);
        chk({d, ".cnt_sat"}, sat, e.sat);
        chk({d, ".qed_ready"}, rdy, (e.st == 1 && e.no == e.nd && !e.sat) ? 1 : 0);
        chk({d, ".mismatch"}, mm, e.mm);
        chk({d, ".sticky"}, sk, e.sticky);
        chk({d, ".idx"}, idx, e.idx);
    endtask

    initial begin : monitor
        mdl_t e;
        forever begin
            @(posedge clk); #1;
            if (q0.size() > 0) begin e = q0.pop_front(); cmp("d16", e, st0, no0, nd0, sat0, rdy0, mm0, sk0, idx0); end
            if (q1.size() > 0) begin e = q1.pop_front(); cmp("d4", e, st1, no1, nd1, sat1, rdy1, mm1, sk1, idx1); end
        end
    end

    // One clock: drive, predict, clock, then let the register file absorb the writes.
    task automatic cyc(input bit r, input bit en, input bit w0, input int d0, input logic [31:0] v0,
                       input bit w1, input int d1, input logic [31:0] v1);
        rst = r; enable = en;
        we_v[0] = w0; dst_v[0] = d0; we_v[1] = w1; dst_v[1] = d1;
        m0 = step(m0, 65535); m1 = step(m1, 15);
        q0.push_back(m0); q1.push_back(m1);
        @(posedge clk); #1;
        if (!r) begin
            if (w0 && d0 != 0) rf[d0] = v0;
            if (w1 && d1 != 0) rf[d1] = v1;
        end
        #1;
        if (st0 == 2'd1) run_seen++;
    endtask

    task automatic idle(input bit en);
        cyc(1'b0, en, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        for (int r = 0; r < NR; r++) rf[r] = '0;
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 3, 0, 1'b1, 20, 0);
        run_seen = 0;
    endtask

    initial begin : stim
        int i, g, d0, d1;
        bit w0, w1;
        logic [31:0] v, v0, v1;
        for (int r = 0; r < NR; r++) rf[r] = '0;

        // Balanced duplicate stream, then hold in PASS
        do_reset();
        idle(1'b0); idle(1'b0); idle(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 3, 5, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 19, 5);
        g = 0;
        while (m0.st == 1 && g < 200) begin
            g++;
            i = $urandom_range(1, H - 1); v = $urandom;
            if ($urandom_range(0, 2) == 0) cyc(1'b0, 1'b0, 1'b1, i, v, 1'b1, i + H, v);
            else begin
                cyc(1'b0, 1'b0, 1'b1, i, v, 1'b1, 0, $urandom);
                cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, i + H, v);
            end
        end
        chk("run_len", run_seen, TO);
        chk("s1_pass", st0, 2);
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 4, 1, 1'b1, 25, 2);

        // Injected corruption: r5/r21 and r7/r23 differ when counts meet
        do_reset();
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 5, 7, 1'b1, 7, 1);
        cyc(1'b0, 1'b0, 1'b1, 21, 9, 1'b1, 23, 2);
        idle(1'b0);
        chk("corr_idx", idx0, 5);
        chk("corr_pulse", mm0, 1);
        repeat (4) idle(1'b0);
        chk("corr_sticky", sk0, 1);
        chk("corr_state", st0, 3);

        // Multi-port classification
        do_reset();
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 2, 11, 1'b1, 18, 11);
        chk("mp_orig1", no0, 1); chk("mp_dup1", nd0, 1);
        cyc(1'b0, 1'b0, 1'b1, 0, 3, 1'b1, 16, 4);
        chk("mp_orig2", no0, 1); chk("mp_dup2", nd0, 2);
        cyc(1'b0, 1'b0, 1'b1, 4, 6, 1'b1, 9, 8);
        chk("mp_orig3", no0, 3);
        g = 0;
        while (m0.st == 1 && g < 100) begin g++; idle(1'b0); end

        // Saturation: narrow counters pin, stop checking and still PASS
        do_reset();
        idle(1'b1);
        repeat (10) cyc(1'b0, 1'b0, 1'b1, 1, 0, 1'b1, 2, 0);
        chk("sat_orig", no1, 15); chk("sat_flag", sat1, 1);
        rf[4] = 32'd123;
        repeat (10) cyc(1'b0, 1'b0, 1'b1, 17, 0, 1'b1, 18, 0);
        chk("sat_rdy", rdy1, 0);
        g = 0;
        while ((m0.st == 1 || m1.st == 1) && g < 100) begin g++; idle(1'b0); end
        chk("sat_pass", st1, 2);
        chk("wide_fail", st0, 3);

        // Hit on the timeout cycle beats PASS; its commit still counts
        do_reset();
        idle(1'b1);
        g = 0;
        while (m0.st == 1 && m0.tmr < TO - 1 && g < 100) begin g++; idle(1'b0); end
        rf[9] = 32'd3;
        cyc(1'b0, 1'b0, 1'b1, 2, 0, 1'b0, 0, 0);
        chk("to_fail", st0, 3); chk("to_cnt", no0, 1);

        // Reset in RUN cycle 10
        do_reset();
        idle(1'b1);
        for (int k = 1; k <= 3; k++) cyc(1'b0, 1'b0, 1'b1, k, 0, 1'b0, 0, 0);
        repeat (6) idle(1'b0);
        chk("mr_orig", no0, 3);
        cyc(1'b1, 1'b1, 1'b1, 5, 0, 1'b1, 21, 0);
        chk("mr_state", st0, 0); chk("mr_orig0", no0, 0);
        idle(1'b1);
        chk("mr_restart", st0, 1);
        repeat (3) idle(1'b0);

        // Random runs: mostly consistent copies with occasional corruption
        repeat (5) begin
            do_reset();
            repeat ($urandom_range(0, 3)) idle(1'b0);
            idle(1'b1);
            g = 0;
            while (m0.st == 1 && g < 80) begin
                g++;
                w0 = 1'($urandom_range(0, 1)); d0 = $urandom_range(0, NR - 1);
                w1 = 1'($urandom_range(0, 1)); d1 = $urandom_range(0, NR - 1);
                if (d1 == d0) w1 = 1'b0;
                v0 = (d0 >= H && $urandom_range(0, 7) != 0) ? rf[d0-H] : 32'($urandom_range(0, 3));
                v1 = (d1 >= H && $urandom_range(0, 7) != 0) ? rf[d1-H] : 32'($urandom_range(0, 3));
                cyc(1'b0, 1'b0, w0, d0, v0, w1, d1, v1);
            end
            repeat (2) idle(1'b0);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drain0", q0.size(), 0);
        chk("sb_drain1", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
